return_stack: RTL



---
 rtl/return_stack_pkg.sv | 29 ++
 rtl/return_stack_mem.sv | 25 ++
 rtl/return_stack.sv | 108 ++++++++++
 3 files changed

// File: rtl/return_stack_pkg.sv
// Shared constants and operation decode for the return-address stack.
package return_stack_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 16;
  localparam int STACK_CW    = $clog2(STACK_DEPTH + 1);

  // Effective stack operation after qualifying the strobes with wesp.
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_e;

  // Push+pop on an empty stack degrades to a plain push.
  function automatic stack_op_e decode_op(input logic wesp, input logic push,
                                          input logic pop, input logic empty);
    stack_op_e op;
    op = OP_NONE;
    if (wesp) begin
      if (push && pop && !empty) op = OP_REPLACE;
      else if (push)             op = OP_PUSH;
      else if (pop)              op = OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/return_stack_mem.sv
// Register array for the return stack: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack: stores PC+1 on call, presents the top entry
// combinationally for return, tracks fill level and sticky error flags.
//
// Strobe semantics: no handshake. push/pop are single-cycle commands that
// take effect at the rising edge when wesp=1; the stack accepts one command
// every cycle and never stalls. q is valid in the same cycle as pop.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wesp,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_waddr;
  logic             w_we;
  logic [WIDTH-1:0] w_rdata;
  stack_op_e        w_op;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  // Low bits of sp minus one; at sp==DEPTH the low bits are 0 and wrap to DEPTH-1.
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign w_op      = decode_op(wesp, push, pop, w_empty);

  // Select write address and enable for push and replace-top.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sp[AW-1:0];
    if (!reset) begin
      case (w_op)
        OP_PUSH: begin
          w_we    = !w_full;
          w_waddr = r_sp[AW-1:0];
        end
        OP_REPLACE: begin
          w_we    = 1'b1;
          w_waddr = w_top_idx;
        end
        default: ;
      endcase
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (d),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  // Stack pointer and sticky flags; reset dominates any concurrent command.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (w_full) r_ovf <= 1'b1;
          else        r_sp  <= r_sp + CW'(1);
        end
        OP_POP: begin
          if (w_empty) r_unf <= 1'b1;
          else         r_sp  <= r_sp - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign q     = w_empty ? '0 : w_rdata;
  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_sp;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
